vertex_fetch_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port vertex ROM (96-bit {x,y,z} words, read-only) among several fetch requesters, e.g. facet-driven vertex fetchers for different objects or pipeline lanes. It grants at most one address per cycle and drives the ROM address register. It tracks in-flight reads through a tag pipeline matched to the ROM read latency, and steers each returned word back to its requester with a one-hot response strobe. Optional per-requester lock lets a fetcher pull all three vertices of a triangle back-to-back, with a bounded burst length.

---
 rtl/vertex_fetch_arbiter.sv | 130 +++++++++++++
 tb/tb_vertex_fetch_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_fetch_arbiter.sv
// vertex_fetch_arbiter: round-robin arbiter with optional bounded lock in front of a
// single-port vertex ROM. It issues at most one read per cycle, registers the ROM
// address, and carries a {valid, index} tag alongside each read so the returned word
// can be steered back to the requester that asked for it.
module vertex_fetch_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 96,
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned MAX_BURST   = 3
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [NUM_REQ-1:0]                  req_in,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_in,
    input  logic [NUM_REQ-1:0]                  lock_in,
    output logic [NUM_REQ-1:0]                  gnt_out,
    output logic [ADDR_WIDTH-1:0]               ram_addr_out,
    input  logic [DATA_WIDTH-1:0]               ram_data_in,
    output logic [NUM_REQ-1:0]                  rsp_valid_out,
    output logic [DATA_WIDTH-1:0]               rsp_data_out,
    output logic                                busy_out
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int unsigned STAGES = RAM_LATENCY + 1;

    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    // Arbitration state
    logic [IDX_W-1:0]              last_gnt;
    logic                          lock_pend;
    logic [CNT_W-1:0]              burst_cnt;

    // In-flight read tags, stage STAGES-1 lines up with ram_data_in
    logic [STAGES-1:0]             tag_vld;
    logic [STAGES-1:0][IDX_W-1:0]  tag_idx;

    // Combinational decisions
    logic                          rr_found;
    logic [IDX_W-1:0]              rr_idx;
    logic [IDX_W-1:0]              rr_cand;
    logic                          lock_win;
    logic                          gnt_any;
    logic [IDX_W-1:0]              gnt_idx;
    logic                          lock_nxt;
    logic [CNT_W-1:0]              burst_nxt;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_cand = IDX_W'((32'(last_gnt) + k) % NUM_REQ);
            if (!rr_found && req_in[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // The previous grantee keeps the port while it holds lock and the burst is not spent
    assign lock_win = lock_pend && req_in[last_gnt] && (burst_cnt < BURST_MAX);

    // Grant selection and next lock/burst state
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = last_gnt;
        gnt_out   = '0;
        lock_nxt  = 1'b0;
        burst_nxt = '0;
        if (!rst_in) begin
            if (lock_win) begin
                gnt_any = 1'b1;
                gnt_idx = last_gnt;
            end else if (rr_found) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx;
            end
        end
        if (gnt_any) begin
            gnt_out[gnt_idx] = 1'b1;
            lock_nxt         = lock_in[gnt_idx];
            if (lock_in[gnt_idx]) begin
                // A round-robin grant with lock held opens a new burst of length one
                burst_nxt = lock_win ? (burst_cnt + CNT_W'(1)) : CNT_W'(1);
            end
        end
    end

    // Arbitration state, ROM address register and tag pipeline
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_gnt     <= LAST_RST;
            lock_pend    <= 1'b0;
            burst_cnt    <= '0;
            ram_addr_out <= '0;
            tag_vld      <= '0;
            tag_idx      <= '0;
        end else begin
            lock_pend  <= lock_nxt;
            burst_cnt  <= burst_nxt;
            tag_vld[0] <= gnt_any;
            tag_idx[0] <= gnt_idx;
            for (int unsigned s = 1; s < STAGES; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
            if (gnt_any) begin
                last_gnt     <= gnt_idx;
                ram_addr_out <= addr_in[gnt_idx];
            end
        end
    end

    // One-hot response strobe from the last tag stage, silenced while in reset
    always_comb begin
        rsp_valid_out = '0;
        if (!rst_in && tag_vld[STAGES-1]) begin
            rsp_valid_out[tag_idx[STAGES-1]] = 1'b1;
        end
    end

    assign rsp_data_out = ram_data_in;
    assign busy_out     = !rst_in && (|tag_vld);

endmodule

// File: tb/tb_vertex_fetch_arbiter.sv
// tb_vertex_fetch_arbiter: directed vector table, back-to-back sequence and random
// traffic against a queue-based reference model with a behavioural ROM.
module tb_vertex_fetch_arbiter;

    localparam int unsigned N   = 3;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 96;
    localparam int unsigned LAT = 2;
    localparam int unsigned MB  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0]         lock;
    logic [N-1:0][AW-1:0] addr;
    logic [N-1:0]         gnt;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_data;
    logic [N-1:0]         rsp_v;
    logic [DW-1:0]        rsp_data;
    logic                 busy;

    always #5 clk = ~clk;

    vertex_fetch_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT), .MAX_BURST(MB)
    ) dut (
        .clk_in(clk), .rst_in(rst), .req_in(req), .addr_in(addr), .lock_in(lock),
        .gnt_out(gnt), .ram_addr_out(ram_addr), .ram_data_in(ram_data),
        .rsp_valid_out(rsp_v), .rsp_data_out(rsp_data), .busy_out(busy)
    );

    // Behavioural ROM: word is a fixed function of its address, LAT cycles after the address
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w * 32'h9E37_79B9 + 32'd1, w ^ 32'hA5A5_0F0F, ~w};
    endfunction

    logic [AW-1:0] rpipe [LAT];
    always @(posedge clk) begin
        rpipe[0] <= ram_addr;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_data = rom_word(rpipe[LAT-1]);

    // Reference model: outstanding reads as a queue of {due cycle, requester, address}
    typedef struct {
        int            due;
        int            idx;
        logic [AW-1:0] a;
    } pend_t;

    pend_t         q[$];
    int            m_last;
    int            m_burst;
    bit            m_pend;
    logic [AW-1:0] m_addr;
    int            m_g;
    bit            m_lw;
    int            cyc;
    int            total;
    int            bad;

    task chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and compare every output with the model
    task step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] lk,
              input logic [N-1:0][AW-1:0] ad);
        logic [N-1:0] eg;
        logic [N-1:0] er;
        rst  = r;
        req  = rq;
        lock = lk;
        addr = ad;
        #1;
        m_g  = -1;
        m_lw = 1'b0;
        if (!r) begin
            if (m_pend && rq[m_last] && m_burst < MB) begin
                m_g  = m_last;
                m_lw = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (m_g < 0 && rq[(m_last + k) % N]) m_g = (m_last + k) % N;
                end
            end
        end
        eg = '0;
        if (m_g >= 0) eg[m_g] = 1'b1;
        chk("gnt", gnt, eg);
        chk("ram_addr", ram_addr, m_addr);
        chk("busy", busy, (!r && q.size() != 0));
        er = '0;
        if (!r && q.size() != 0 && q[0].due == cyc) begin
            er[q[0].idx] = 1'b1;
            chk("rsp_data", rsp_data, rom_word(q[0].a));
            void'(q.pop_front());
        end
        chk("rsp_valid", rsp_v, er);
    endtask

    // Commit the cycle into the model, then move to the next low clock phase
    task advance();
        if (rst) begin
            q.delete();
            m_last  = N - 1;
            m_pend  = 1'b0;
            m_burst = 0;
            m_addr  = '0;
        end else if (m_g >= 0) begin
            if (lock[m_g]) m_burst = m_lw ? m_burst + 1 : 1;
            else           m_burst = 0;
            m_pend = lock[m_g];
            m_last = m_g;
            m_addr = addr[m_g];
            q.push_back('{cyc + 1 + LAT, m_g, addr[m_g]});
        end else begin
            m_pend  = 1'b0;
            m_burst = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    typedef struct {
        bit           r;
        logic [N-1:0] rq;
        logic [N-1:0] lk;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        bit           eb;
    } vec_t;

    vec_t tab[44];

    initial begin
        logic [N-1:0][AW-1:0] ad;

        // rst, req, lock, expected gnt, expected rsp_valid, expected busy
        tab[0]  = '{1'b0, 3'b010, 3'b000, 3'b010, 3'b000, 1'b0};
        tab[1]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
        tab[2]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
        tab[3]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1};
        tab[4]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[5]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[6]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b000, 1'b0};
        tab[7]  = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b000, 1'b1};
        tab[8]  = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b000, 1'b1};
        tab[9]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b001, 1'b1};
        tab[10] = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b010, 1'b1};
        tab[11] = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b100, 1'b1};
        tab[12] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 1'b1};
        tab[13] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1};
        tab[14] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b1};
        tab[15] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[16] = '{1'b0, 3'b010, 3'b010, 3'b010, 3'b000, 1'b0};
        tab[17] = '{1'b0, 3'b111, 3'b010, 3'b010, 3'b000, 1'b1};
        tab[18] = '{1'b0, 3'b111, 3'b010, 3'b010, 3'b000, 1'b1};
        tab[19] = '{1'b0, 3'b111, 3'b010, 3'b100, 3'b010, 1'b1};
        tab[20] = '{1'b0, 3'b111, 3'b010, 3'b001, 3'b010, 1'b1};
        tab[21] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1};
        tab[22] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b1};
        tab[23] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 1'b1};
        tab[24] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[25] = '{1'b0, 3'b110, 3'b010, 3'b010, 3'b000, 1'b0};
        tab[26] = '{1'b0, 3'b110, 3'b010, 3'b010, 3'b000, 1'b1};
        tab[27] = '{1'b0, 3'b110, 3'b010, 3'b010, 3'b000, 1'b1};
        tab[28] = '{1'b0, 3'b110, 3'b010, 3'b100, 3'b010, 1'b1};
        tab[29] = '{1'b0, 3'b110, 3'b010, 3'b010, 3'b010, 1'b1};
        tab[30] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1};
        tab[31] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b100, 1'b1};
        tab[32] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1};
        tab[33] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[34] = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b000, 1'b0};
        tab[35] = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b000, 1'b1};
        tab[36] = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[37] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[38] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
        tab[39] = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b000, 1'b0};
        tab[40] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
        tab[41] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
        tab[42] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 1'b1};
        tab[43] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};

        total   = 0;
        bad     = 0;
        cyc     = 0;
        m_last  = N - 1;
        m_pend  = 1'b0;
        m_burst = 0;
        m_addr  = '0;
        m_g     = -1;
        rst     = 1'b1;
        req     = '0;
        lock    = '0;
        addr    = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state with requests present
        step(1'b1, 3'b111, 3'b111, '0);
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_addr", ram_addr, 16'h0000);
        advance();

        // Directed vectors
        for (int i = 0; i < 44; i++) begin
            for (int j = 0; j < N; j++) ad[j] = AW'(i * 8 + j);
            step(tab[i].r, tab[i].rq, tab[i].lk, ad);
            chk($sformatf("tab%0d_gnt", i), gnt, tab[i].eg);
            chk($sformatf("tab%0d_rsp", i), rsp_v, tab[i].er);
            chk($sformatf("tab%0d_busy", i), busy, tab[i].eb);
            advance();
        end

        // Back-to-back reads from requester 0 with addresses 0..11
        for (int k = 0; k < 12; k++) begin
            ad    = '0;
            ad[0] = AW'(k);
            step(1'b0, 3'b001, 3'b000, ad);
            chk($sformatf("b2b%0d_gnt", k), gnt, 3'b001);
            if (k > 0) chk($sformatf("b2b%0d_addr", k), ram_addr, AW'(k - 1));
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 3'b000, 3'b000, '0);
            if (k == 0) chk("b2b_last_addr", ram_addr, 16'd11);
            advance();
        end

        // Random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < N; j++) ad[j] = AW'($urandom);
            step(($urandom_range(0, 63) == 0), N'($urandom), N'($urandom), ad);
            advance();
        end
        for (int k = 0; k < LAT + 3; k++) begin
            step(1'b0, 3'b000, 3'b000, '0);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
